spi_regbus_decoder: RTL and testbench



---
 rtl/spi_regbus_decoder.sv | 150 +++++++++++++++
 tb/tb_spi_regbus_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbus_decoder.sv
// Byte-stream command decoder: turns SPI bytes into 16-bit register bus writes/reads
// and streams read data back to the transceiver one byte at a time.
module spi_regbus_decoder #(
  parameter int unsigned ADDR_W    = 7,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ack_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_ack_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [15:0]       reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [15:0]       reg_rdata_i
);

  typedef enum logic [2:0] {
    S_CMD,
    S_WR_HI,
    S_WR_LO,
    S_RD_ISSUE,
    S_RD_CAP,
    S_RD_HI,
    S_RD_LO
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        tx_data_nxt;
  logic              tx_ack_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       wdata_nxt;
  logic              we_nxt;
  logic              re_nxt;
  logic [7:0]        hi_byte, hi_byte_nxt;
  logic [7:0]        lo_byte, lo_byte_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_CMD;
      tx_data_o   <= 8'h00;
      tx_ack_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= 16'h0000;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      hi_byte     <= 8'h00;
      lo_byte     <= 8'h00;
    end else begin
      state       <= state_nxt;
      tx_data_o   <= tx_data_nxt;
      tx_ack_o    <= tx_ack_nxt;
      reg_addr_o  <= addr_nxt;
      reg_wdata_o <= wdata_nxt;
      reg_we_o    <= we_nxt;
      reg_re_o    <= re_nxt;
      hi_byte     <= hi_byte_nxt;
      lo_byte     <= lo_byte_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_data_nxt = tx_data_o;
    tx_ack_nxt  = 1'b0;
    addr_nxt    = reg_addr_o;
    wdata_nxt   = reg_wdata_o;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    hi_byte_nxt = hi_byte;
    lo_byte_nxt = lo_byte;

    // Post-write increment belongs to the completed write, so a transaction restart does not cancel it.
    if (reg_we_o) begin
      addr_nxt = reg_addr_o + ADDR_ONE;
    end

    if (spi_rst_i) begin
      state_nxt   = S_CMD;
      tx_ack_nxt  = 1'b1;
      tx_data_nxt = FILL_BYTE;
    end else begin
      unique case (state)
        S_CMD: begin
          if (rx_ack_i) begin
            addr_nxt    = rx_data_i[ADDR_W-1:0];
            tx_ack_nxt  = 1'b1;
            tx_data_nxt = FILL_BYTE;
            if (rx_data_i[7]) begin
              state_nxt = S_WR_HI;
            end else begin
              state_nxt = S_RD_ISSUE;
              re_nxt    = 1'b1;
            end
          end
        end
        S_WR_HI: begin
          if (rx_ack_i) begin
            hi_byte_nxt = rx_data_i;
            tx_ack_nxt  = 1'b1;
            tx_data_nxt = FILL_BYTE;
            state_nxt   = S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (rx_ack_i) begin
            tx_ack_nxt  = 1'b1;
            tx_data_nxt = FILL_BYTE;
            wdata_nxt   = {hi_byte, rx_data_i};
            we_nxt      = 1'b1;
            state_nxt   = S_WR_HI;
          end
        end
        // reg_re_o is already high here; read data arrives while in S_RD_CAP.
        S_RD_ISSUE: begin
          state_nxt = S_RD_CAP;
        end
        S_RD_CAP: begin
          tx_ack_nxt  = 1'b1;
          tx_data_nxt = reg_rdata_i[15:8];
          lo_byte_nxt = reg_rdata_i[7:0];
          state_nxt   = S_RD_HI;
        end
        S_RD_HI: begin
          if (rx_ack_i) begin
            tx_ack_nxt  = 1'b1;
            tx_data_nxt = lo_byte;
            state_nxt   = S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (rx_ack_i) begin
            addr_nxt  = reg_addr_o + ADDR_ONE;
            re_nxt    = 1'b1;
            state_nxt = S_RD_ISSUE;
          end
        end
        default: begin
          state_nxt = S_CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regbus_decoder.sv
// Directed bench for spi_regbus_decoder: byte-level write/read transactions with a
// small register-file responder and monitors that log bus strobes and tx bytes.
module tb_spi_regbus_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_ack_i;
  logic [7:0]  tx_data_o;
  logic        tx_ack_o;
  logic [6:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [15:0] reg_rdata_i;

  spi_regbus_decoder #(.ADDR_W(7), .FILL_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_rst_i  (spi_rst_i),
    .rx_data_i  (rx_data_i),
    .rx_ack_i   (rx_ack_i),
    .tx_data_o  (tx_data_o),
    .tx_ack_o   (tx_ack_o),
    .reg_addr_o (reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_we_o   (reg_we_o),
    .reg_re_o   (reg_re_o),
    .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  int last_ack_cyc = 0;

  logic [15:0] mem [0:127];
  logic [31:0] txq[$];
  logic [31:0] weq[$];
  logic [31:0] req[$];
  logic [31:0] we_lat[$];
  logic [31:0] re_lat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] or_all(input logic [31:0] q[$]);
    logic [31:0] acc = 32'h0;
    foreach (q[i]) acc |= q[i];
    return acc;
  endfunction

  always @(posedge clk) begin
    cyc++;
    reg_rdata_i <= reg_re_o ? mem[reg_addr_o] : 16'h0000;
  end

  always @(negedge clk) begin
    if (rx_ack_i) last_ack_cyc = cyc;
    if (tx_ack_o) txq.push_back({24'h0, tx_data_o});
    if (reg_we_o) begin
      weq.push_back({9'h0, reg_addr_o, reg_wdata_o});
      we_lat.push_back(32'(cyc - last_ack_cyc));
    end
    if (reg_re_o) begin
      req.push_back({25'h0, reg_addr_o});
      re_lat.push_back(32'(cyc - last_ack_cyc));
    end
  end

  task automatic clear_logs();
    txq.delete(); weq.delete(); req.delete(); we_lat.delete(); re_lat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data_i = b;
    rx_ack_i  = 1'b1;
    @(posedge clk); #1;
    rx_ack_i  = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic spi_start();
    @(posedge clk); #1;
    spi_rst_i = 1'b1;
    @(posedge clk); #1;
    spi_rst_i = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'(i * 3);
    mem[7'h7F] = 16'hBEEF;
    mem[7'h00] = 16'hCAFE;
    rst_n = 1'b0; spi_rst_i = 1'b0; rx_data_i = 8'h00; rx_ack_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr",    {25'h0, reg_addr_o}, 32'h0);
    chk("rst_wdata",   {16'h0, reg_wdata_o}, 32'h0);
    chk("rst_txdata",  {24'h0, tx_data_o}, 32'h0);
    chk("rst_strobes", {29'h0, tx_ack_o, reg_we_o, reg_re_o}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write, two words from 0x05
    spi_start(); clear_logs();
    send_byte(8'h85); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    chk("wr_count", weq.size(), 2);
    chk("wr_word0", at(weq, 0), {9'h0, 7'h05, 16'h1234});
    chk("wr_word1", at(weq, 1), {9'h0, 7'h06, 16'h5678});
    chk("wr_lat",   at(we_lat, 0), 1);
    chk("wr_txcnt", txq.size(), 5);
    chk("wr_txfill", or_all(txq), 0);
    chk("wr_addr_after", {25'h0, reg_addr_o}, 32'h07);
    chk("wr_no_re", req.size(), 0);

    // Read from 0x7F with wrap to 0x00
    spi_start(); clear_logs();
    send_byte(8'h7F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("rd_re_count", req.size(), 2);
    chk("rd_re_addr0", at(req, 0), 32'h7F);
    chk("rd_re_addr1", at(req, 1), 32'h00);
    chk("rd_re_lat",   at(re_lat, 0), 1);
    chk("rd_txcnt", txq.size(), 5);
    chk("rd_tx0", at(txq, 0), 32'h00);
    chk("rd_tx1", at(txq, 1), 32'hBE);
    chk("rd_tx2", at(txq, 2), 32'hEF);
    chk("rd_tx3", at(txq, 3), 32'hCA);
    chk("rd_tx4", at(txq, 4), 32'hFE);
    chk("rd_no_we", weq.size(), 0);

    // Aborted write, then a fresh single-word write
    spi_start(); clear_logs();
    send_byte(8'h80); send_byte(8'hAA);
    spi_start();
    chk("abort_no_we", weq.size(), 0);
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h01);
    chk("abort_we_count", weq.size(), 1);
    chk("abort_word", at(weq, 0), {9'h0, 7'h01, 16'h0001});
    chk("abort_txcnt", txq.size(), 6);
    chk("abort_txfill", or_all(txq), 0);

    // spi_rst_i in the same cycle as the write strobe
    spi_start(); clear_logs();
    send_byte(8'h82); send_byte(8'h11);
    @(posedge clk); #1;
    rx_data_i = 8'h22; rx_ack_i = 1'b1;
    @(posedge clk); #1;
    rx_ack_i = 1'b0; spi_rst_i = 1'b1;
    @(posedge clk); #1;
    spi_rst_i = 1'b0;
    repeat (6) @(posedge clk);
    chk("race_we_count", weq.size(), 1);
    chk("race_word", at(weq, 0), {9'h0, 7'h02, 16'h1122});
    send_byte(8'h83); send_byte(8'h33); send_byte(8'h44);
    chk("race_next_word", at(weq, 1), {9'h0, 7'h03, 16'h3344});
    chk("race_txcnt", txq.size(), 7);
    chk("race_txfill", or_all(txq), 0);

    // rst_n low in S_RD_HI, with spi_rst_i asserted alongside
    spi_start(); clear_logs();
    send_byte(8'h7F);
    chk("prec_tx_hi", at(txq, 1), 32'hBE);
    clear_logs();
    @(posedge clk); #1;
    rst_n = 1'b0; spi_rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("prec_addr",  {25'h0, reg_addr_o}, 32'h0);
    chk("prec_wdata", {16'h0, reg_wdata_o}, 32'h0);
    chk("prec_txdata", {24'h0, tx_data_o}, 32'h0);
    chk("prec_strobes", {29'h0, tx_ack_o, reg_we_o, reg_re_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; spi_rst_i = 1'b0;
    repeat (10) @(posedge clk);
    chk("prec_no_re", req.size(), 0);
    chk("prec_no_tx", txq.size(), 0);
    send_byte(8'h84); send_byte(8'hAB); send_byte(8'hCD);
    chk("prec_we_count", weq.size(), 1);
    chk("prec_word", at(weq, 0), {9'h0, 7'h04, 16'hABCD});
    chk("prec_re_after", req.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
